// File: rtl/lsu_axi_bridge_if.sv
// ---------------------------------------------------------------------------
// lsu_axi_bridge_if
//
// Bundles the two buses seen by lsu_axi_bridge:
//   io_*  : single-beat request/response interface from the load/store unit.
//   m_*   : AXI4-Lite master channels (AW, W, B, AR, R).
//   dbg_* : captured request fields that have no effect on the bus.
//
// Modports:
//   master : the bridge itself (LSU-side responder, AXI master).
//   slave  : the environment (LSU as requester, AXI slave as responder).
// ---------------------------------------------------------------------------
interface lsu_axi_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  localparam int STRB_W = DATA_W / 8;

  // LSU side
  logic              io_reqValid;
  logic              io_respValid;
  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wdata;
  logic [STRB_W-1:0] io_wmask;
  logic [1:0]        io_size;
  logic              io_wen;
  logic [DATA_W-1:0] io_rdata;
  logic              io_err;

  // Debug view of the captured request
  logic [1:0]        dbg_size;
  logic              dbg_wen;

  // AXI4-Lite write address / data / response
  logic [ADDR_W-1:0] m_awaddr;
  logic              m_awvalid;
  logic              m_awready;
  logic [DATA_W-1:0] m_wdata;
  logic [STRB_W-1:0] m_wstrb;
  logic              m_wvalid;
  logic              m_wready;
  logic [1:0]        m_bresp;
  logic              m_bvalid;
  logic              m_bready;

  // AXI4-Lite read address / data
  logic [ADDR_W-1:0] m_araddr;
  logic              m_arvalid;
  logic              m_arready;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rvalid;
  logic              m_rready;

  modport master (
    input  io_reqValid, io_addr, io_wdata, io_wmask, io_size, io_wen,
    output io_respValid, io_rdata, io_err,
    output dbg_size, dbg_wen,
    output m_awaddr, m_awvalid, input m_awready,
    output m_wdata, m_wstrb, m_wvalid, input m_wready,
    input  m_bresp, m_bvalid, output m_bready,
    output m_araddr, m_arvalid, input m_arready,
    input  m_rdata, m_rresp, m_rvalid, output m_rready
  );

  modport slave (
    output io_reqValid, io_addr, io_wdata, io_wmask, io_size, io_wen,
    input  io_respValid, io_rdata, io_err,
    input  dbg_size, dbg_wen,
    input  m_awaddr, m_awvalid, output m_awready,
    input  m_wdata, m_wstrb, m_wvalid, output m_wready,
    output m_bresp, m_bvalid, input m_bready,
    input  m_araddr, m_arvalid, output m_arready,
    output m_rdata, m_rresp, m_rvalid, input m_rready
  );

endinterface

// File: rtl/lsu_axi_bridge.sv
// ---------------------------------------------------------------------------
// lsu_axi_bridge
//
// Converts each single-beat LSU request into exactly one AXI4-Lite master
// transaction, one transaction outstanding at a time. Read data and a
// one-cycle completion pulse (with error flag) are returned to the LSU.
//
// Ports:
//   clock : system clock.
//   reset : synchronous, active-high reset.
//   bus   : lsu_axi_bridge_if.master - LSU io_* signals, AXI m_* channels
//           and the dbg_* view of the captured request.
//
// Transaction flow:
//   IDLE -> WR -> WR_RESP -> DONE -> IDLE        (write)
//   IDLE -> RD_ADDR -> RD_DATA -> DONE -> IDLE   (read)
// All valid/ready/response outputs are registered; AXI addresses are the
// word-aligned captured request address.
// ---------------------------------------------------------------------------
module lsu_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic             clock,
  input logic             reset,
  lsu_axi_bridge_if.master bus
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_DONE
  } state_t;

  state_t state;

  // Captured request. Only the word address is kept: the bus always sees
  // word-aligned addresses and the LSU handles the byte offset.
  logic [ADDR_W-1:2] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wmask_q;
  logic              wen_q;
  logic [1:0]        size_q;

  // Write-phase progress: AW and W complete independently.
  logic aw_done;
  logic w_done;

  // Registered bus / response outputs
  logic              awvalid_q;
  logic              wvalid_q;
  logic              arvalid_q;
  logic              bready_q;
  logic              rready_q;
  logic              resp_valid_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic aw_hs;
  logic w_hs;

  assign aw_hs = awvalid_q && bus.m_awready;
  assign w_hs  = wvalid_q  && bus.m_wready;

  // NOTE: every register, including the capture registers, is cleared by the
  // synchronous reset so a mid-transaction reset leaves no stale payload or
  // pending valid behind.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      wen_q        <= 1'b0;
      size_q       <= '0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      rready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; the completion pulse is
      // defaulted low here and only raised on the cycle entering DONE.
      resp_valid_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.io_reqValid) begin
            addr_q  <= bus.io_addr[ADDR_W-1:2];
            wdata_q <= bus.io_wdata;
            wmask_q <= bus.io_wmask;
            wen_q   <= bus.io_wen;
            size_q  <= bus.io_size;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (bus.io_wen) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= S_WR;
            end else begin
              arvalid_q <= 1'b1;
              state     <= S_RD_ADDR;
            end
          end
        end

        S_WR: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done   <= 1'b1;
          end
          // Either channel may finish first, or both in the same cycle.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            bready_q <= 1'b1;
            state    <= S_WR_RESP;
          end
        end

        S_WR_RESP: begin
          if (bready_q && bus.m_bvalid) begin
            bready_q     <= 1'b0;
            err_q        <= (bus.m_bresp != 2'b00);
            resp_valid_q <= 1'b1;
            state        <= S_DONE;
          end
        end

        S_RD_ADDR: begin
          if (arvalid_q && bus.m_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= S_RD_DATA;
          end
        end

        S_RD_DATA: begin
          if (rready_q && bus.m_rvalid) begin
            rready_q     <= 1'b0;
            rdata_q      <= bus.m_rdata;
            err_q        <= (bus.m_rresp != 2'b00);
            resp_valid_q <= 1'b1;
            state        <= S_DONE;
          end
        end

        // The pulse is visible during DONE; a held io_reqValid is ignored
        // here and only re-examined once back in IDLE.
        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.m_awaddr  = {addr_q, 2'b00};
  assign bus.m_awvalid = awvalid_q;
  assign bus.m_wdata   = wdata_q;
  assign bus.m_wstrb   = wmask_q;
  assign bus.m_wvalid  = wvalid_q;
  assign bus.m_bready  = bready_q;
  assign bus.m_araddr  = {addr_q, 2'b00};
  assign bus.m_arvalid = arvalid_q;
  assign bus.m_rready  = rready_q;

  assign bus.io_respValid = resp_valid_q;
  assign bus.io_rdata     = rdata_q;
  assign bus.io_err       = err_q;

  assign bus.dbg_size = size_q;
  assign bus.dbg_wen  = wen_q;

endmodule

// File: tb/tb_lsu_axi_bridge.sv
// ---------------------------------------------------------------------------
// tb_lsu_axi_bridge
//
// The bench plays both the LSU and the AXI slave. For every request it plans
// the whole transaction timeline with plain cycle arithmetic (when each valid
// must be up, which cycle each ready/response is offered, when the pulse
// lands) into per-cycle expectation tables. One compare process checks the
// DUT against those tables every cycle; a few literal checks pin the model.
// Cycle n is the interval ending at the n-th rising edge; inputs are driven
// and outputs sampled on the falling edge inside it.
// ---------------------------------------------------------------------------
module tb_lsu_axi_bridge;

  localparam int NC = 4096;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  lsu_axi_bridge_if bus ();

  lsu_axi_bridge dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Expected DUT outputs for one cycle (all zero = idle bus, no pulse).
  typedef struct {
    bit        awv, wv, arv, br, rr, resp, err, rd_new;
    bit [31:0] addr, wdata, rdata;
    bit [3:0]  wstrb;
  } exp_t;

  // Slave responses planned for one cycle.
  typedef struct {
    bit        awr, wr, arr, bv, rv;
    bit [1:0]  bresp, rresp;
    bit [31:0] rdata;
  } in_t;

  exp_t exp_q   [NC];
  in_t  inp     [NC];
  bit   rst_eff [NC];

  int          cyc        = 0;
  int          tests      = 0;
  int          fails      = 0;
  int          pulses     = 0;
  int          exp_pulses = 0;
  bit          chk_en     = 1'b0;
  logic [31:0] exp_rdata  = '0;

  logic [31:0] s_araddr1;
  logic        s_awv2, s_wv2;
  logic [3:0]  s_wstrb2;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // AXI slave: offers the planned handshakes; elsewhere it toggles readies
  // and response valids randomly, but only while the DUT must not be
  // listening on that channel.
  always @(negedge clock) begin : slave
    in_t  i;
    exp_t e;
    if (cyc < NC) begin
      i = inp[cyc];
      e = exp_q[cyc];
      bus.m_awready = i.awr | (!e.awv & rb());
      bus.m_wready  = i.wr  | (!e.wv  & rb());
      bus.m_arready = i.arr | (!e.arv & rb());
      bus.m_bvalid  = i.bv  | (!e.br  & rb());
      bus.m_bresp   = i.bv ? i.bresp : 2'($urandom_range(0, 3));
      bus.m_rvalid  = i.rv  | (!e.rr  & rb());
      bus.m_rresp   = i.rv ? i.rresp : 2'($urandom_range(0, 3));
      bus.m_rdata   = i.rv ? i.rdata : $urandom;
    end
  end

  // Compare process: DUT outputs against the planned timeline, every cycle.
  always @(negedge clock) begin : cmp
    exp_t e;
    if (chk_en && cyc < NC) begin
      e = exp_q[cyc];
      if (rst_eff[cyc]) exp_rdata = '0;
      if (e.rd_new)     exp_rdata = e.rdata;
      check("ctl{aw,w,ar,b,r,resp}",
            32'({bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_bready, bus.m_rready, bus.io_respValid}),
            32'({e.awv, e.wv, e.arv, e.br, e.rr, e.resp}));
      if (e.awv) check("awaddr", bus.m_awaddr, e.addr);
      if (e.wv) begin
        check("wdata", bus.m_wdata, e.wdata);
        check("wstrb", 32'(bus.m_wstrb), 32'(e.wstrb));
      end
      if (e.arv)  check("araddr", bus.m_araddr, e.addr);
      if (e.resp) check("io_err", 32'(bus.io_err), 32'(e.err));
      check("io_rdata", bus.io_rdata, exp_rdata);
      if (bus.io_respValid === 1'b1) pulses++;
    end
  end

  task automatic next_cycle();
    @(negedge clock);
  endtask

  // Transaction timeline from the acceptance cycle T and slave delays.
  task automatic plan(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wmask, input int t, input int da, input int dw,
                      input int db, input int dr, input logic [1:0] resp,
                      input logic [31:0] rdata, output int p);
    int a, w, d, b, r;
    logic [31:0] wa;
    wa = addr & 32'hFFFF_FFFC;
    if (wen) begin
      a = t + 1 + da;
      w = t + 1 + dw;
      d = (a > w) ? a : w;
      b = d + 1 + db;
      p = b + 1;
      for (int c = t + 1; c <= a; c++) begin exp_q[c].awv = 1'b1; exp_q[c].addr = wa; end
      for (int c = t + 1; c <= w; c++) begin
        exp_q[c].wv = 1'b1; exp_q[c].wdata = wdata; exp_q[c].wstrb = wmask;
      end
      for (int c = d + 1; c <= b; c++) exp_q[c].br = 1'b1;
      inp[a].awr = 1'b1;
      inp[w].wr  = 1'b1;
      inp[b].bv  = 1'b1;
      inp[b].bresp = resp;
    end else begin
      a = t + 1 + da;
      r = a + 1 + dr;
      p = r + 1;
      for (int c = t + 1; c <= a; c++) begin exp_q[c].arv = 1'b1; exp_q[c].addr = wa; end
      for (int c = a + 1; c <= r; c++) exp_q[c].rr = 1'b1;
      inp[a].arr   = 1'b1;
      inp[r].rv    = 1'b1;
      inp[r].rresp = resp;
      inp[r].rdata = rdata;
      exp_q[p].rd_new = 1'b1;
      exp_q[p].rdata  = rdata;
    end
    exp_q[p].resp = 1'b1;
    exp_q[p].err  = (resp != 2'b00);
  endtask

  task automatic scramble();
    bus.io_addr  = $urandom;
    bus.io_wdata = $urandom;
    bus.io_wmask = 4'($urandom_range(0, 15));
    bus.io_size  = 2'($urandom_range(0, 3));
  endtask

  // LSU side of one request: optional idle gap, present the request, hold
  // io_reqValid through the pulse cycle while the payload wanders.
  task automatic do_txn(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wmask, input int da, input int dw, input int db,
                        input int dr, input logic [1:0] resp, input logic [31:0] rdata,
                        input int gap, output int t, output int p);
    for (int g = 0; g < gap; g++) begin
      next_cycle();
      bus.io_reqValid = 1'b0;
      bus.io_wen      = rb();
      scramble();
    end
    next_cycle();
    t = cyc;
    bus.io_reqValid = 1'b1;
    bus.io_wen      = wen;
    bus.io_addr     = addr;
    bus.io_wdata    = wdata;
    bus.io_wmask    = wmask;
    bus.io_size     = 2'($urandom_range(0, 3));
    plan(wen, addr, wdata, wmask, t, da, dw, db, dr, resp, rdata, p);
    for (int c = t + 1; c <= p; c++) begin
      next_cycle();
      scramble();
      if (c == t + 1) s_araddr1 = bus.m_araddr;
      if (c == t + 2) begin
        s_awv2   = bus.m_awvalid;
        s_wv2    = bus.m_wvalid;
        s_wstrb2 = bus.m_wstrb;
      end
    end
    exp_pulses++;
  endtask

  initial begin : watchdog
    #(NC * 10 * 4);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int t, p, n0;
    bus.io_reqValid = 1'b0;
    bus.io_wen      = 1'b0;
    bus.io_addr     = '0;
    bus.io_wdata    = '0;
    bus.io_wmask    = '0;
    bus.io_size     = '0;
    reset = 1'b1;

    // Reset state
    next_cycle();                 // cycle 0
    next_cycle();                 // cycle 1: reset has taken effect
    chk_en = 1'b1;
    check("reset_ctl",
          32'({bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_bready, bus.m_rready,
               bus.io_respValid, bus.io_err}), 32'd0);
    check("reset_rdata", bus.io_rdata, 32'd0);
    next_cycle();
    reset = 1'b0;

    // Read, zero-wait slave
    do_txn(1'b0, 32'h8000_0006, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 32'hCAFE_BABE, 0, t, p);
    check("rd0_latency", p - t, 32'd3);
    check("rd0_araddr", s_araddr1, 32'h8000_0004);
    check("rd0_resp", 32'(bus.io_respValid), 32'd1);
    check("rd0_rdata", bus.io_rdata, 32'hCAFE_BABE);
    check("rd0_err", 32'(bus.io_err), 32'd0);

    // Write, awready at T+1, wready three cycles later
    do_txn(1'b1, 32'h0000_0100, 32'h1122_3344, 4'b1100, 0, 3, 0, 0, 2'b00, 32'h0, 1, t, p);
    check("wr1_latency", p - t, 32'd6);
    check("wr1_aw_drop_w_hold", 32'({s_awv2, s_wv2}), 32'b01);
    check("wr1_wstrb", 32'(s_wstrb2), 32'b1100);
    check("wr1_resp", 32'(bus.io_respValid), 32'd1);
    check("wr1_rdata_kept", bus.io_rdata, 32'hCAFE_BABE);

    // Back-to-back split access, io_reqValid held through the pulse
    next_cycle();
    bus.io_reqValid = 1'b0;
    n0 = pulses;
    do_txn(1'b0, 32'h0000_0102, 32'h0, 4'h0, 0, 0, 0, 1, 2'b00, 32'hA5A5_0001, 0, t, p);
    do_txn(1'b0, 32'h0000_0104, 32'h0, 4'h0, 1, 0, 0, 0, 2'b00, 32'hA5A5_0002, 0, t, p);
    check("b2b_rdata", bus.io_rdata, 32'hA5A5_0002);
    next_cycle();
    bus.io_reqValid = 1'b0;
    check("b2b_pulses", pulses - n0, 32'd2);

    // Error response followed by a clean write
    do_txn(1'b0, 32'h4000_0010, 32'h0, 4'h0, 0, 0, 0, 0, 2'b10, 32'hDEAD_BEEF, 1, t, p);
    check("err_rd_flag", 32'({bus.io_respValid, bus.io_err}), 32'b11);
    do_txn(1'b1, 32'h4000_0020, 32'h0BAD_CAFE, 4'hF, 1, 0, 2, 0, 2'b00, 32'h0, 0, t, p);
    check("err_wr_clear", 32'({bus.io_respValid, bus.io_err}), 32'b10);
    check("err_rdata_kept", bus.io_rdata, 32'hDEAD_BEEF);

    // Reset while RD_DATA waits on a stalled rvalid
    next_cycle();
    t = cyc;
    bus.io_reqValid = 1'b1;
    bus.io_wen      = 1'b0;
    bus.io_addr     = 32'h0000_2000;
    plan(1'b0, 32'h0000_2000, 32'h0, 4'h0, t, 0, 0, 0, 6, 2'b00, 32'h55AA_55AA, p);
    repeat (3) next_cycle();      // cycles t+1 .. t+3
    next_cycle();                 // cycle t+4: reset sampled at its end
    reset = 1'b1;
    bus.io_reqValid = 1'b0;
    for (int c = t + 5; c <= p; c++) begin
      exp_q[c] = '{default: '0};
      inp[c]   = '{default: '0};
    end
    rst_eff[t + 5] = 1'b1;
    next_cycle();                 // cycle t+5
    reset = 1'b0;
    check("rst_ctl",
          32'({bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_bready, bus.m_rready,
               bus.io_respValid}), 32'd0);
    check("rst_rdata", bus.io_rdata, 32'd0);
    do_txn(1'b0, 32'h3000_0008, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 32'h0BAD_F00D, 0, t, p);
    check("rst_fresh_rdata", bus.io_rdata, 32'h0BAD_F00D);

    // Randomized traffic
    for (int n = 0; n < 200 && cyc < NC - 40; n++) begin
      bit          wen;
      logic [1:0]  resp;
      wen  = rb();
      resp = rb() ? 2'b00 : 2'($urandom_range(0, 3));
      do_txn(wen, $urandom, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), resp, $urandom, $urandom_range(0, 2), t, p);
    end

    next_cycle();
    bus.io_reqValid = 1'b0;
    repeat (3) next_cycle();
    check("pulse_total", pulses, exp_pulses);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
